decryption_input_demux: RTL and testbench
=========================================

// Module: decryption_input_demux
// PURPOSE
//  Input-side stage that feeds the three cipher engines (Caesar, Scytale, ZigZag).
//  - Accepts an encrypted character stream.
//  - Buffers the stream in a small FIFO.
//  - Routes each message to the one engine chosen by the regfile select output,
//    respecting each engine's busy back-pressure.
//  - Message boundaries are marked by END_CHAR; select is sampled once per message.
// PARAMETERS
//  D_WIDTH     8      character width
//  REG_WIDTH   16     width of select_i (matches regfile register width)
//  FIFO_DEPTH  4      buffer entries, power of two, >= 2
//  END_CHAR    8'hFA  end-of-message marker; it is forwarded to the engine
// PORTS
//  clk           in   1          system clock
//  rst_n         in   1          asynchronous active-low reset
//  data_i        in   D_WIDTH    incoming encrypted character
//  valid_i       in   1          data_i valid; a char is accepted when valid_i && ready_o
//  ready_o       out  1          block can accept a char this cycle
//  select_i      in   REG_WIDTH  cipher select from regfile; only [1:0] used
//  busy_caesar_i in   1          Caesar engine busy; no char is issued to it while high
//  busy_scyt_i   in   1          Scytale engine busy
//  busy_zz_i     in   1          ZigZag engine busy
//  data_o        out  D_WIDTH    shared output data bus to all engines
//  valid_caesar_o out 1          data_o valid for Caesar (1-cycle pulse)
//  valid_scyt_o  out  1          data_o valid for Scytale
//  valid_zz_o    out  1          data_o valid for ZigZag
//  err_o         out  1          1-cycle pulse: message started with invalid select
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO emptied; state=IDLE.
//   - data_o=0, all valid_*_o=0, err_o=0.
//   - ready_o=0 while in reset, =1 from the first clk after release.
//  Select decode: 0 Caesar, 1 Scytale, 2 ZigZag, 3 invalid. Bits [REG_WIDTH-1:2] ignored.
//  FSM states: IDLE, ROUTE, DRAIN, DROP.
//   IDLE:
//    - Accepted char latches select_i[1:0] into sel_q; char pushed to FIFO.
//    - sel_q==3 -> DROP; err_o=1 next cycle; char discarded, not pushed.
//    - Otherwise -> ROUTE.
//    - If the first char is END_CHAR: push it and go directly to DRAIN (empty message).
//   ROUTE:
//    - Accepted chars are pushed to the FIFO.
//    - Accepting END_CHAR -> DRAIN.
//    - select_i changes are ignored until the next IDLE.
//   DRAIN:
//    - ready_o=0.
//    - Return to IDLE on the cycle the END_CHAR is popped.
//   DROP:
//    - ready_o=1; chars are accepted and discarded.
//    - Accepting END_CHAR -> IDLE; no valid_* pulses are produced.
//  ready_o = !fifo_full in IDLE/ROUTE; 1 in DROP; 0 in DRAIN.
//   - A full FIFO blocks a push even when a pop happens in the same cycle.
//  Pop/issue:
//   - If FIFO is non-empty and the busy input of the engine selected by sel_q is low:
//     pop one entry; next cycle data_o=entry and that engine's valid=1 for 1 cycle.
//   - Max one pop per cycle; back-to-back issue is allowed while busy stays low.
//   - data_o holds its last value when no valid is asserted.
//  Latency: char accepted at edge N with empty FIFO and busy low
//   -> data_o/valid at edge N+1.
//  Simultaneous push and pop: allowed when not full; occupancy is unchanged.
//  Ordering: strict FIFO, with no loss or duplication; valid outputs are one-hot or zero.
//  Busy rising while entries remain: issue stalls and entries are held;
//   ready_o drops when the FIFO is full.
//  Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
//  Reset mid-message: all state is lost; the next accepted char starts a new message.
// TESTING
//  1. select=0, send 'A','B',FA with busy low
//     -> valid_caesar_o pulses with 41,42,FA on consecutive cycles; latency 1.
//  2. select=2, send 6 chars with busy_zz_i high
//     -> 4 accepted, ready_o=0; release busy -> all 6 + FA delivered in order.
//  3. select=3, send 'X',FA
//     -> err_o single pulse; no valid_* pulses; back to IDLE; next message routes normally.
//  4. select changed 1->0 mid-message
//     -> whole message still goes to Scytale; the next message goes to Caesar.
//  5. DRAIN: after FA, valid_i held high
//     -> ready_o=0 until FA is delivered, then the next char is accepted in IDLE.
//  6. rst_n pulsed low with 3 chars buffered
//     -> outputs 0 immediately (async); FIFO empty; no stale chars delivered after reset.

Source files
------------

// File: rtl/decryption_input_demux.sv
// decryption_input_demux: buffers an encrypted character stream in a small FIFO
// and routes each END_CHAR-terminated message to the cipher engine picked by the
// select input, which is sampled on the first character of each message.
module decryption_input_demux #(
   parameter int                 D_WIDTH    = 8,
   parameter int                 REG_WIDTH  = 16,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [D_WIDTH-1:0] END_CHAR   = 8'hFA
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [REG_WIDTH-1:0] select_i,
   input  logic                 busy_caesar_i,
   input  logic                 busy_scyt_i,
   input  logic                 busy_zz_i,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_caesar_o,
   output logic                 valid_scyt_o,
   output logic                 valid_zz_o,
   output logic                 err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] SEL_CAESAR  = 2'd0;
   localparam logic [1:0] SEL_SCYT    = 2'd1;
   localparam logic [1:0] SEL_ZZ      = 2'd2;
   localparam logic [1:0] SEL_INVALID = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUTE,
      ST_DRAIN,
      ST_DROP
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic               init_q;
   logic               err_q, err_d;

   logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic [D_WIDTH-1:0] data_q;
   logic               valid_caesar_q, valid_scyt_q, valid_zz_q;

   logic               fifo_full, fifo_empty;
   logic [D_WIDTH-1:0] head;
   logic               busy_sel;
   logic               accept, push, pop;

   // Only the two low select bits carry meaning.
   logic               unused_select;
   assign unused_select = ^select_i[REG_WIDTH-1:2];

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign head       = mem[rd_ptr_q];
   assign accept     = valid_i && ready_o;

   // Back-pressure from whichever engine owns the current message; the invalid
   // code never issues (its FIFO is always empty anyway).
   always_comb begin
      unique case (sel_q)
         SEL_CAESAR: busy_sel = busy_caesar_i;
         SEL_SCYT:   busy_sel = busy_scyt_i;
         SEL_ZZ:     busy_sel = busy_zz_i;
         default:    busy_sel = 1'b1;
      endcase
   end

   assign pop = !fifo_empty && !busy_sel;

   // ready_o: held low in reset and until the first clock after release.
   always_comb begin
      unique case (state_q)
         ST_IDLE, ST_ROUTE: ready_o = init_q && !fifo_full;
         ST_DROP:           ready_o = init_q;
         default:           ready_o = 1'b0;
      endcase
   end

   // Next-state, select capture, push and error decisions.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned
      // (which would infer a latch).
      state_d = state_q;
      sel_d   = sel_q;
      push    = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (select_i[1:0] == SEL_INVALID) begin
                  sel_d   = SEL_INVALID;
                  err_d   = 1'b1;
                  state_d = (data_i == END_CHAR) ? ST_IDLE : ST_DROP;
               end else begin
                  sel_d   = select_i[1:0];
                  push    = 1'b1;
                  state_d = (data_i == END_CHAR) ? ST_DRAIN : ST_ROUTE;
               end
            end
         end
         ST_ROUTE: begin
            if (accept) begin
               push = 1'b1;
               if (data_i == END_CHAR) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && head == END_CHAR) state_d = ST_IDLE;
         end
         ST_DROP: begin
            if (accept && data_i == END_CHAR) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state, FIFO pointers/occupancy and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         sel_q          <= SEL_CAESAR;
         init_q         <= 1'b0;
         err_q          <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         data_q         <= '0;
         valid_caesar_q <= 1'b0;
         valid_scyt_q   <= 1'b0;
         valid_zz_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         sel_q    <= sel_d;
         init_q   <= 1'b1;
         err_q    <= err_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
         if (pop) data_q <= head;
         valid_caesar_q <= pop && (sel_q == SEL_CAESAR);
         valid_scyt_q   <= pop && (sel_q == SEL_SCYT);
         valid_zz_q     <= pop && (sel_q == SEL_ZZ);
      end
   end

   // FIFO storage.
   // NOTE: the storage array has no reset; occupancy and pointers alone decide
   // what is valid, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= data_i;
   end

   assign data_o         = data_q;
   assign valid_caesar_o = valid_caesar_q;
   assign valid_scyt_o   = valid_scyt_q;
   assign valid_zz_o     = valid_zz_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_decryption_input_demux.sv
// Testbench for decryption_input_demux: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based message model.
module tb_decryption_input_demux;

   localparam int         DEPTH = 4;
   localparam logic [7:0] END_C = 8'hFA;
   localparam int M_IDLE = 0, M_ROUTE = 1, M_DRAIN = 2, M_DROP = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_i;
   logic        valid_i;
   logic        ready_o;
   logic [15:0] select_i;
   logic        busy_caesar_i, busy_scyt_i, busy_zz_i;
   logic [7:0]  data_o;
   logic        valid_caesar_o, valid_scyt_o, valid_zz_o;
   logic        err_o;

   decryption_input_demux dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_i         (data_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .select_i       (select_i),
      .busy_caesar_i  (busy_caesar_i),
      .busy_scyt_i    (busy_scyt_i),
      .busy_zz_i      (busy_zz_i),
      .data_o         (data_o),
      .valid_caesar_o (valid_caesar_o),
      .valid_scyt_o   (valid_scyt_o),
      .valid_zz_o     (valid_zz_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: message mode, buffered characters, owning engine.
   logic [7:0] m_fifo[$];
   int         m_mode;
   int         m_eng;
   bit         m_init;
   logic [7:0] exp_data;
   bit         exp_vc, exp_vs, exp_vz, exp_err;
   bit         last_acc;

   // Logs of what the DUT delivered, for directed scenario checks.
   logic [7:0] log_c[$], log_s[$], log_z[$];
   int         err_cnt;

   task automatic clear_logs();
      log_c.delete(); log_s.delete(); log_z.delete();
      err_cnt = 0;
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_mode   = M_IDLE;
      m_eng    = 0;
      m_init   = 1'b0;
      exp_data = 8'h00;
      exp_vc = 0; exp_vs = 0; exp_vz = 0; exp_err = 0;
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_data"},   data_o,         exp_data);
      check({pfx, "_vc"},     valid_caesar_o, exp_vc);
      check({pfx, "_vs"},     valid_scyt_o,   exp_vs);
      check({pfx, "_vz"},     valid_zz_o,     exp_vz);
      check({pfx, "_err"},    err_o,          exp_err);
   endtask

   // One clock cycle: check ready, advance the model across the edge, check outputs.
   task automatic tick();
      bit         exp_ready, acc, do_pop;
      bit [2:0]   busy_vec;
      logic [7:0] d, e;
      logic [1:0] s;
      int         old_mode;
      exp_ready = m_init && (m_mode == M_DROP ||
                  ((m_mode == M_IDLE || m_mode == M_ROUTE) && m_fifo.size() < DEPTH));
      check("ready", ready_o, exp_ready);
      acc      = valid_i && exp_ready;
      busy_vec = {busy_zz_i, busy_scyt_i, busy_caesar_i};
      do_pop   = (m_fifo.size() != 0) && !busy_vec[m_eng];
      d        = data_i;
      s        = select_i[1:0];
      @(posedge clk);
      m_init  = 1'b1;
      exp_vc = 0; exp_vs = 0; exp_vz = 0; exp_err = 0;
      old_mode = m_mode;
      if (do_pop) begin
         e = m_fifo.pop_front();
         exp_data = e;
         if (m_eng == 0) exp_vc = 1;
         else if (m_eng == 1) exp_vs = 1;
         else exp_vz = 1;
         if (old_mode == M_DRAIN && e == END_C) m_mode = M_IDLE;
      end
      if (acc) begin
         case (old_mode)
            M_IDLE: begin
               if (s == 2'd3) begin
                  exp_err = 1;
                  m_mode  = (d == END_C) ? M_IDLE : M_DROP;
               end else begin
                  m_eng = int'(s);
                  m_fifo.push_back(d);
                  m_mode = (d == END_C) ? M_DRAIN : M_ROUTE;
               end
            end
            M_ROUTE: begin
               m_fifo.push_back(d);
               if (d == END_C) m_mode = M_DRAIN;
            end
            M_DROP: if (d == END_C) m_mode = M_IDLE;
            default: ;
         endcase
      end
      last_acc = acc;
      @(negedge clk);
      check_outputs("out");
      if (valid_caesar_o) log_c.push_back(data_o);
      if (valid_scyt_o)   log_s.push_back(data_o);
      if (valid_zz_o)     log_z.push_back(data_o);
      if (err_o)          err_cnt++;
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) tick();
   endtask

   // Present one char and clock until it is accepted (bounded).
   task automatic send(input logic [7:0] d);
      int tries = 0;
      valid_i = 1'b1;
      data_i  = d;
      do begin
         tick();
         tries++;
      end while (!last_acc && tries < 100);
      if (!last_acc) check("send_timeout", 0, 1);
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_ready", ready_o, 1'b0);
      check_outputs("rst");
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [7:0] rand_char();
      logic [7:0] c = 8'($urandom_range(0, 255));
      if (c == END_C) c = 8'h00;
      return c;
   endfunction

   logic [7:0] msg[7];
   int idx, tries, held_acc;

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00; select_i = 16'h0000;
      busy_caesar_i = 0; busy_scyt_i = 0; busy_zz_i = 0;
      model_reset();
      #2;
      check("por_ready", ready_o, 1'b0);
      check_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // 1: Caesar message, latency one, back-to-back delivery.
      clear_logs();
      select_i = 16'hAB00;
      send(8'h41); send(8'h42); send(END_C);
      idle(4);
      check("t1_cnt", log_c.size(), 3);
      if (log_c.size() == 3) begin
         check("t1_c0", log_c[0], 8'h41);
         check("t1_c1", log_c[1], 8'h42);
         check("t1_c2", log_c[2], END_C);
      end

      // 2: ZigZag busy -> FIFO fills to 4, then drains in order.
      clear_logs();
      select_i = 16'h0002;
      busy_zz_i = 1;
      for (int i = 0; i < 6; i++) msg[i] = rand_char();
      msg[6] = END_C;
      idx = 0;
      valid_i = 1'b1;
      repeat (8) begin
         data_i = msg[idx];
         tick();
         if (last_acc) idx++;
      end
      check("t2_acc", idx, 4);
      check("t2_ready", ready_o, 1'b0);
      busy_zz_i = 0;
      tries = 0;
      while (idx < 7 && tries < 100) begin
         data_i = msg[idx];
         tick();
         if (last_acc) idx++;
         tries++;
      end
      idle(8);
      check("t2_cnt", log_z.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < log_z.size()) check("t2_order", log_z[i], msg[i]);

      // 3: invalid select drops the message, then normal routing resumes.
      clear_logs();
      select_i = 16'h0003;
      send(8'h58); send(END_C);
      idle(3);
      check("t3_err", err_cnt, 1);
      check("t3_novalid", log_c.size() + log_s.size() + log_z.size(), 0);
      select_i = 16'h0001;
      send(8'h51); send(END_C);
      idle(3);
      check("t3_scyt", log_s.size(), 2);

      // 4: select change mid-message is ignored until the next message.
      clear_logs();
      select_i = 16'h0001;
      send(8'h61);
      select_i = 16'h0000;
      send(8'h62); send(END_C);
      idle(3);
      send(8'h63); send(END_C);
      idle(3);
      check("t4_scyt", log_s.size(), 3);
      check("t4_caesar", log_c.size(), 2);

      // 5: DRAIN refuses input until the END_CHAR has been delivered.
      clear_logs();
      select_i = 16'h0000;
      busy_caesar_i = 1;
      send(8'h70); send(END_C);
      data_i = 8'h6E;
      held_acc = 0;
      repeat (5) begin
         tick();
         if (last_acc) held_acc++;
      end
      check("t5_held", held_acc, 0);
      busy_caesar_i = 0;
      send(8'h6E); send(END_C);
      idle(4);
      check("t5_caesar", log_c.size(), 4);

      // 6: reset with buffered chars leaves nothing to deliver.
      select_i = 16'h0000;
      busy_caesar_i = 1;
      send(8'h11); send(8'h22); send(8'h33);
      valid_i = 1'b0;
      do_reset();
      clear_logs();
      busy_caesar_i = 0;
      idle(8);
      check("t6_stale", log_c.size(), 0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         valid_i  = ($urandom_range(0, 9) < 7);
         data_i   = ($urandom_range(0, 7) == 0) ? END_C : rand_char();
         select_i = {14'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2))};
         busy_caesar_i = ($urandom_range(0, 9) < 3);
         busy_scyt_i   = ($urandom_range(0, 9) < 3);
         busy_zz_i     = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 499) == 0) do_reset();
         tick();
      end
      busy_caesar_i = 0; busy_scyt_i = 0; busy_zz_i = 0;
      idle(10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
